// File: rtl/mem_access_unit_if.sv
// Request/response port bundle between the CPU datapath (master) and
// mem_access_unit (slave).
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/halfword/word load-store initiator in front of a
// word-organised memory with whole-word write enable. Sub-word stores are
// done as read-modify-write. Loads return sign/zero-extended data.
// Optional feature macro: MEM_ACCESS_ALIGN_CHECK_EN -- when defined,
// misaligned halfword/word requests complete immediately with resp_err=1
// and touch no memory; when undefined, misaligned low address bits are
// ignored and resp_err stays 0.
module mem_access_unit #(
  parameter int LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_access_unit_if.slave bus,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_write,
  input  logic [31:0]      mem_rdata
);
  typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE, RESP} state_t;

  // Wait counter reload value: the read phase lasts LAT cycles.
  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        write_q;
  logic        signed_q;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic        misaligned;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [31:0] merged;

  assign bus.req_ready = (state == IDLE);

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  assign misaligned = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                      (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Pick the addressed lane out of the read word and extend it to 32 bits.
  always_comb begin
    ld_byte = mem_rdata[{lane_q, 3'b000} +: 8];
    ld_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   ld_ext = signed_q ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
      2'b01:   ld_ext = signed_q ? {{16{ld_half[15]}}, ld_half} : {16'h0, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  // Read-modify-write merge: each byte lane either keeps the read data or
  // takes the matching byte of the right-aligned store data.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic hit;
      assign hit = (size_q == 2'b00) ? (lane_q == 2'(gi)) : (lane_q[1] == 1'(gi / 2));
      assign merged[8*gi +: 8] = !hit ? mem_rdata[8*gi +: 8] :
                                 ((size_q == 2'b01) && ((gi % 2) == 1)) ? wdata_q[15:8] :
                                 wdata_q[7:0];
    end
  endgenerate

  // Transaction FSM with registered memory and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      write_q        <= 1'b0;
      signed_q       <= 1'b0;
      size_q         <= 2'b00;
      lane_q         <= 2'b00;
      wdata_q        <= 16'h0;
      mem_addr       <= 32'h0;
      mem_wdata      <= 32'h0;
      mem_write      <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.resp_rdata <= 32'h0;
    end else begin
      mem_write      <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            write_q        <= bus.req_write;
            signed_q       <= bus.req_signed;
            size_q         <= bus.req_size;
            lane_q         <= bus.req_addr[1:0];
            wdata_q        <= bus.req_wdata[15:0];
            mem_addr       <= {2'b00, bus.req_addr[31:2]};
            bus.resp_rdata <= 32'h0;
            if (misaligned) begin
              // Rejected without any memory access.
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              state          <= RESP;
            end else if (bus.req_write && bus.req_size[1]) begin
              // Whole-word store needs no read.
              mem_wdata <= bus.req_wdata;
              mem_write <= 1'b1;
              state     <= WRITE;
            end else begin
              cnt   <= CNT_INIT;
              state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (cnt == 4'd0) begin
            if (write_q) begin
              mem_wdata <= merged;
              mem_write <= 1'b1;
              state     <= WRITE;
            end else begin
              bus.resp_rdata <= ld_ext;
              bus.resp_valid <= 1'b1;
              state          <= RESP;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WRITE: begin
          bus.resp_rdata <= 32'h0;
          bus.resp_valid <= 1'b1;
          state          <= RESP;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
